// File: rtl/crc_pkt_gen_pkg.sv
// Shared CRC-32 constants, ctrl-word field offsets and the packet FSM encoding.
package crc_pkt_gen_pkg;

   localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

   localparam int CTRL_DEST_LSB = 0;
   localparam int CTRL_PRIO_LSB = 4;
   localparam int CTRL_LEN_LSB  = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CTRL,
      ST_DATA,
      ST_CRC,
      ST_EOP
   } state_t;

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   // The engine shifts LSB-first, so it works with the bit-reversed polynomial.
   localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

endpackage

// File: rtl/crc_pkt_gen_crc32_step.sv
// Combinational CRC-32 update over the low nbytes lanes of one data word,
// highest of those lanes first; zero latency, no flow control.
module crc32_step
   import crc_pkt_gen_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [31:0]                crc_in,
   input  logic [DATA_W-1:0]          data_in,
   input  logic [$clog2(DATA_W/8):0]  nbytes,
   output logic [31:0]                crc_out
);
   localparam int NB = DATA_W / 8;

   logic [31:0] c;

   always_comb begin
      c = crc_in;
      for (int k = 0; k < NB; k++) begin
         // Lanes at or above nbytes are not part of this word's payload.
         if ((NB - 1 - k) < int'(nbytes)) begin
            c = c ^ {24'd0, data_in[8*(NB-1-k) +: 8]};
            for (int j = 0; j < 8; j++) begin
               c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
            end
         end
      end
      crc_out = c;
   end

endmodule

// File: rtl/crc_pkt_gen.sv
// Packet CRC-32 appender: sop/ctrl/payload forwarded at 1-cycle latency, then CRC word, then eop.
// No backpressure, oRdy only gates a new sop; CRC_STATS_EN adds saturating oPktCnt/oErrCnt.
module crc_pkt_gen
   import crc_pkt_gen_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 10
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iWrSop,
   input  logic              iWrEop,
   input  logic              iWrVld,
   input  logic [DATA_W-1:0] iWrData,
   output logic              oWrSop,
   output logic              oWrEop,
   output logic              oWrVld,
   output logic [DATA_W-1:0] oWrData,
   output logic              oRdy,
   output logic              oLenErr
`ifdef CRC_STATS_EN
   ,
   output logic [15:0]       oPktCnt,
   output logic [15:0]       oErrCnt
`endif
);
   localparam int NB   = DATA_W / 8;
   localparam int NB_W = $clog2(NB) + 1;

   state_t            state_q, state_d;
   logic [31:0]       crc_q, crc_d;
   logic [LEN_W:0]    rem_q, rem_d;
   logic              err_q, err_d;
   logic              sop_q, sop_d;
   logic              eop_q, eop_d;
   logic              vld_q, vld_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              rdy_q, rdy_d;
   logic              len_err_q, len_err_d;

   logic [NB_W-1:0]   nbytes;
   logic [31:0]       step_crc;

   assign nbytes = (rem_q >= (LEN_W+1)'(NB)) ? NB_W'(NB) : rem_q[NB_W-1:0];

   crc32_step #(.DATA_W(DATA_W)) u_step (
      .crc_in  (crc_q),
      .data_in (iWrData),
      .nbytes  (nbytes),
      .crc_out (step_crc)
   );

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      rem_d     = rem_q;
      err_d     = err_q;
      sop_d     = 1'b0;
      eop_d     = 1'b0;
      vld_d     = 1'b0;
      data_d    = '0;
      len_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            crc_d = CRC_INIT;
            rem_d = '0;
            err_d = 1'b0;
            if (iWrSop && rdy_q) begin
               sop_d   = 1'b1;
               state_d = ST_CTRL;
            end
         end
         ST_CTRL: begin
            // Eop before any ctrl word: crc_q is still CRC_INIT, so the CRC word comes out as zero.
            if (iWrEop) begin
               err_d   = 1'b1;
               vld_d   = 1'b1;
               data_d  = DATA_W'(crc_q ^ CRC_XOROUT);
               state_d = ST_CRC;
            end else if (iWrVld) begin
               vld_d   = 1'b1;
               data_d  = iWrData;
               rem_d   = (LEN_W+1)'(iWrData[CTRL_LEN_LSB +: LEN_W]) + (LEN_W+1)'(1);
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (iWrEop) begin
               if (rem_q != '0) err_d = 1'b1;
               vld_d   = 1'b1;
               data_d  = DATA_W'(crc_q ^ CRC_XOROUT);
               state_d = ST_CRC;
            end else if (iWrVld) begin
               vld_d  = 1'b1;
               data_d = iWrData;
               if (rem_q == '0) begin
                  err_d = 1'b1;
               end else begin
                  crc_d = step_crc;
                  rem_d = rem_q - (LEN_W+1)'(nbytes);
               end
            end
         end
         ST_CRC: begin
            eop_d     = 1'b1;
            len_err_d = err_q;
            state_d   = ST_EOP;
         end
         ST_EOP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      rdy_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q   <= ST_IDLE;
         crc_q     <= CRC_INIT;
         rem_q     <= '0;
         err_q     <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         vld_q     <= 1'b0;
         data_q    <= '0;
         rdy_q     <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         rem_q     <= rem_d;
         err_q     <= err_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         vld_q     <= vld_d;
         data_q    <= data_d;
         rdy_q     <= rdy_d;
         len_err_q <= len_err_d;
      end
   end

   assign oWrSop  = sop_q;
   assign oWrEop  = eop_q;
   assign oWrVld  = vld_q;
   assign oWrData = data_q;
   assign oRdy    = rdy_q;
   assign oLenErr = len_err_q;

`ifdef CRC_STATS_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      err_cnt_d = err_cnt_q;
      if (eop_d && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (len_err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign oPktCnt = pkt_cnt_q;
   assign oErrCnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_pkt_gen.sv
// Bench for crc_pkt_gen at DATA_W=32 and DATA_W=64: directed and random packets vs a byte-stream CRC model.
module tb_crc_pkt_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sop32, eop32, vld32;
   logic [31:0] dat32;
   logic        sop64, eop64, vld64;
   logic [63:0] dat64;
   logic        o_sop32, o_eop32, o_vld32, o_rdy32, o_lerr32;
   logic [31:0] o_dat32;
   logic        o_sop64, o_eop64, o_vld64, o_rdy64, o_lerr64;
   logic [63:0] o_dat64;
`ifdef CRC_STATS_EN
   logic [15:0] pkt32, err32, pkt64, err64;
`endif

   crc_pkt_gen #(.DATA_W(32), .LEN_W(10)) dut32 (
      .iClk(clk), .iRst(rst), .iWrSop(sop32), .iWrEop(eop32), .iWrVld(vld32), .iWrData(dat32),
      .oWrSop(o_sop32), .oWrEop(o_eop32), .oWrVld(o_vld32), .oWrData(o_dat32),
      .oRdy(o_rdy32), .oLenErr(o_lerr32)
`ifdef CRC_STATS_EN
      , .oPktCnt(pkt32), .oErrCnt(err32)
`endif
   );

   crc_pkt_gen #(.DATA_W(64), .LEN_W(10)) dut64 (
      .iClk(clk), .iRst(rst), .iWrSop(sop64), .iWrEop(eop64), .iWrVld(vld64), .iWrData(dat64),
      .oWrSop(o_sop64), .oWrEop(o_eop64), .oWrVld(o_vld64), .oWrData(o_dat64),
      .oRdy(o_rdy64), .oLenErr(o_lerr64)
`ifdef CRC_STATS_EN
      , .oPktCnt(pkt64), .oErrCnt(err64)
`endif
   );

   typedef struct {
      int          kind;   // 0 sop, 1 valid word, 2 eop
      logic [63:0] dat;
      logic        lerr;
      int          cyc;
   } ev_t;

   ev_t         mon32[$];
   ev_t         mon64[$];
   ev_t         exp_q[$];
   logic [63:0] pay[$];
   logic [7:0]  bytes_q[$];
   logic [63:0] last_dat;
   int          cyc = 0;
   int          stray_lerr = 0;
   int          n_assert = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_sop32) mon32.push_back('{0, 64'd0, 1'b0, cyc});
      if (o_vld32) mon32.push_back('{1, {32'd0, o_dat32}, 1'b0, cyc});
      if (o_eop32) mon32.push_back('{2, 64'd0, o_lerr32, cyc});
      if (o_sop64) mon64.push_back('{0, 64'd0, 1'b0, cyc});
      if (o_vld64) mon64.push_back('{1, o_dat64, 1'b0, cyc});
      if (o_eop64) mon64.push_back('{2, 64'd0, o_lerr64, cyc});
      if ((o_lerr32 && !o_eop32) || (o_lerr64 && !o_eop64)) stray_lerr++;
   end

   task automatic chk64(input logic [63:0] obs, input logic [63:0] expv, input string tag);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic rdy_of(input bit w64);
      return w64 ? o_rdy64 : o_rdy32;
   endfunction

   // Standard reflected CRC-32 over the byte stream the packet rules select.
   function automatic logic [31:0] crc32_model();
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (bytes_q[k]) begin
         c = c ^ {24'd0, bytes_q[k]};
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic drive(input bit w64, input bit s, input bit e, input bit v, input logic [63:0] d);
      @(negedge clk);
      sop32 = !w64 && s;  eop32 = !w64 && e;  vld32 = !w64 && v;  dat32 = w64 ? 32'd0 : d[31:0];
      sop64 = w64 && s;   eop64 = w64 && e;   vld64 = w64 && v;   dat64 = w64 ? d : 64'd0;
   endtask

   task automatic check_zero(input string tag);
      chk64(64'({o_sop32, o_eop32, o_vld32, o_lerr32, o_rdy32, o_dat32}), 64'd0, {tag, " out32"});
      chk64({o_sop64, o_eop64, o_vld64, o_lerr64, o_rdy64}, 5'd0, {tag, " ctl64"});
      chk64(o_dat64, 64'd0, {tag, " dat64"});
`ifdef CRC_STATS_EN
      chk64(64'({pkt32, err32, pkt64, err64}), 64'd0, {tag, " stats"});
`endif
   endtask

   task automatic fill_rand(input int n);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back({$urandom, $urandom});
   endtask

   task automatic send_pkt(input bit w64, input int len, input int gap, input bit with_ctrl,
                           input bit sop_after, input int abort_at);
      logic [63:0] mask, ctrl, d;
      logic [31:0] crc;
      int          rem, r, nb;
      bit          err;
      mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      nb   = w64 ? 8 : 4;
      bytes_q.delete();
      rem = len;
      err = !with_ctrl;
      chk64(64'(rdy_of(w64)), 64'd1, "rdy before sop");
      drive(w64, 1, 0, 0, 64'd0);
      exp_q.push_back('{0, 64'd0, 1'b0, cyc + 1});
      if (with_ctrl) begin
         ctrl = (64'(len - 1) << 7) | 64'($urandom_range(0, 127));
         drive(w64, 0, 0, 1, ctrl);
         exp_q.push_back('{1, ctrl, 1'b0, cyc + 1});
         chk64(64'(rdy_of(w64)), 64'd0, "rdy in packet");
         for (int i = 0; i < pay.size(); i++) begin
            repeat (gap) drive(w64, 0, 0, 0, 64'd0);
            d = pay[i] & mask;
            drive(w64, 0, 0, 1, d);
            if (i == abort_at) begin
               @(posedge clk);
               #2 rst = 1'b1;
               #1 check_zero("abort");
               repeat (2) drive(w64, 0, 0, 0, 64'd0);
               rst = 1'b0;
               repeat (3) drive(w64, 0, 0, 0, 64'd0);
               return;
            end
            exp_q.push_back('{1, d, 1'b0, cyc + 1});
            if (rem == 0) begin
               err = 1'b1;
            end else begin
               r = (rem < nb) ? rem : nb;
               for (int b = r - 1; b >= 0; b--) bytes_q.push_back(d[8*b +: 8]);
               rem -= r;
            end
         end
         if (rem > 0) err = 1'b1;
      end
      drive(w64, 0, 1, 0, 64'd0);
      crc = crc32_model();
      exp_q.push_back('{1, {32'd0, crc}, 1'b0, cyc + 1});
      exp_q.push_back('{2, 64'd0, err, cyc + 2});
      if (sop_after) drive(w64, 1, 0, 0, 64'd0);
      repeat (4) drive(w64, 0, 0, 0, 64'd0);
   endtask

   task automatic check_events(input bit w64, input string tag);
      ev_t got[$];
      if (w64) begin
         got = mon64;
         mon64.delete();
      end else begin
         got = mon32;
         mon32.delete();
      end
      chk64(64'(got.size()), 64'(exp_q.size()), {tag, " event count"});
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         chk64(64'(got[i].kind), 64'(exp_q[i].kind), $sformatf("%s ev%0d kind", tag, i));
         chk64(got[i].dat, exp_q[i].dat, $sformatf("%s ev%0d data", tag, i));
         chk64(64'(got[i].cyc), 64'(exp_q[i].cyc), $sformatf("%s ev%0d cycle", tag, i));
         chk64(64'(got[i].lerr), 64'(exp_q[i].lerr), $sformatf("%s ev%0d lenerr", tag, i));
      end
      foreach (got[i]) if (got[i].kind == 1) last_dat = got[i].dat;
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      sop32 = 0; eop32 = 0; vld32 = 0; dat32 = '0;
      sop64 = 0; eop64 = 0; vld64 = 0; dat64 = '0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      repeat (3) drive(0, 0, 0, 0, 64'd0);
      chk64(64'({o_rdy32, o_rdy64}), 64'd3, "rdy after reset");

      pay = '{64'h3132_3334, 64'h3536_3738, 64'h0000_0039};
      send_pkt(0, 9, 0, 1, 0, -1);
      check_events(0, "check32");
      chk64(last_dat, 64'h0000_0000_CBF4_3926, "check32 crc");

      pay = '{64'h3132_3334_3536_3738, 64'h0000_0000_0000_0039};
      send_pkt(1, 9, 0, 1, 0, -1);
      check_events(1, "check64");
      chk64(last_dat, 64'h0000_0000_CBF4_3926, "check64 crc");

      fill_rand(16);  send_pkt(0, 64, 0, 1, 0, -1);  check_events(0, "p64b_w32");
      fill_rand(32);  send_pkt(0, 128, 1, 1, 0, -1); check_events(0, "p128b_gap_w32");
      fill_rand(8);   send_pkt(1, 64, 0, 1, 0, -1);  check_events(1, "p64b_w64");
      fill_rand(16);  send_pkt(1, 128, 1, 1, 0, -1); check_events(1, "p128b_gap_w64");

      fill_rand(5);   send_pkt(0, 16, 0, 1, 0, -1);  check_events(0, "overrun");
      fill_rand(3);   send_pkt(0, 20, 0, 1, 0, -1);  check_events(0, "short");
      fill_rand(2);   send_pkt(1, 13, 0, 1, 0, -1);  check_events(1, "partial64");

      pay.delete();
      send_pkt(0, 9, 0, 0, 0, -1);
      check_events(0, "no_ctrl");
      chk64(last_dat, 64'd0, "no_ctrl crc");

      fill_rand(3);
      send_pkt(0, 10, 0, 1, 1, -1);
      check_events(0, "sop_after_eop");
      drive(0, 0, 0, 1, 64'h1234_5678);
      repeat (3) drive(0, 0, 0, 0, 64'd0);
      check_events(0, "idle_vld");

      fill_rand(6);
      send_pkt(0, 24, 0, 1, 0, 2);
      drive(0, 0, 0, 1, 64'h0BAD_F00D);
      repeat (3) drive(0, 0, 0, 0, 64'd0);
      check_events(0, "abort");

      for (int p = 0; p < 3; p++) begin
         fill_rand(3);
         send_pkt(0, 12, 0, 1, 0, -1);
         check_events(0, $sformatf("good%0d", p));
      end
      fill_rand(2);
      send_pkt(0, 12, 0, 1, 0, -1);
      check_events(0, "short_stats");
`ifdef CRC_STATS_EN
      chk64(64'(pkt32), 64'd4, "pkt count");
      chk64(64'(err32), 64'd1, "err count");
      chk64(64'({pkt64, err64}), 64'd0, "idle stats64");
`endif

      for (int it = 0; it < 24; it++) begin
         bit w;
         int nb, ln, nw, gp;
         w  = 1'($urandom_range(0, 1));
         nb = w ? 8 : 4;
         ln = $urandom_range(1, 48);
         nw = (ln + nb - 1) / nb;
         case ($urandom_range(0, 3))
            0:       nw = nw + 1;
            1:       nw = nw - 1;
            default: ;
         endcase
         gp = $urandom_range(0, 2);
         fill_rand(nw);
         send_pkt(w, ln, gp, 1, 0, -1);
         check_events(w, $sformatf("rand%0d", it));
      end

      chk64(64'(stray_lerr), 64'd0, "lenerr without eop");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/crc_pkt_gen.md
CRC_PKT_GEN -- requirements
Module: crc_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data path width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter LEN_W, default 10, width of the (length-1) field in the ctrl word.
REQ-003 iClk  input  1  sole clock; all logic on rising edge.
REQ-004 iRst  input  1  reset, asynchronous, active-high.
REQ-005 iWrSop  input  1  start-of-packet pulse, never coincident with iWrVld.
REQ-006 iWrEop  input  1  end-of-packet pulse, never coincident with iWrVld.
REQ-007 iWrVld  input  1  iWrData qualifier; gaps between words allowed.
REQ-008 iWrData  input  DATA_W  ctrl word then payload words.
REQ-009 oWrSop, oWrEop, oWrVld  output  1 each  output framing, same semantics as the inputs.
REQ-010 oWrData  output  DATA_W  forwarded words plus the appended CRC word.
REQ-011 oRdy  output  1  high when a new iWrSop is accepted.
REQ-012 oLenErr  output  1  one-cycle pulse with oWrEop on payload word-count mismatch.

Function
REQ-013 Ctrl word layout SHALL be bits [LEN_W+6:7]=len-1 (bytes), [6:4]=prio, [3:0]=dest, upper bits zero; forwarded unchanged.
REQ-014 Sop, ctrl and payload words SHALL be forwarded with exactly 1 cycle latency, bit-exact.
REQ-015 FSM states IDLE->CTRL (on iWrSop)->DATA (on ctrl iWrVld)->CRC (on iWrEop)->EOP->IDLE, one cycle each in CRC and EOP.
REQ-016 In CRC state, oWrVld=1 and oWrData={zeros, CRC32} in bits [31:0]; in EOP state, oWrEop=1.
REQ-017 CRC SHALL be IEEE 802.3 CRC-32 (reflected poly 0x04C11DB7, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) over payload bytes only.
REQ-018 Byte order: a full word is processed from lane [DATA_W-1:DATA_W-8] downward; a final partial word with r bytes is right-aligned, processed from lane [8r-1:8r-8] down to [7:0].
REQ-019 Remaining-byte counter SHALL be loaded with len from the ctrl word and decremented by min(remaining, DATA_W/8) per payload word.
REQ-020 Payload words beyond len are forwarded, excluded from the CRC, and set the length-error flag; Eop with remaining>0 also sets it.
REQ-021 oLenErr SHALL pulse with oWrEop when the flag is set; the flag clears in IDLE.
REQ-022 oRdy SHALL be 1 in IDLE only; iWrSop while oRdy=0 is ignored (no oWrSop); iWrVld in IDLE, CRC or EOP is dropped.
REQ-023 iWrEop in CTRL (no ctrl word) SHALL give CRC word 0x00000000 and oLenErr=1.

Reset
REQ-024 While iRst=1: FSM=IDLE, CRC register=0xFFFFFFFF, counters=0, all 1-bit outputs=0, oWrData=0.
REQ-025 Reset mid-packet SHALL abort it immediately with no oWrEop and no CRC word; after release the block waits for a fresh iWrSop.

Configuration
REQ-026 With macro CRC_STATS_EN defined, ports oPktCnt[15:0] (incremented on each oWrEop) and oErrCnt[15:0] (incremented on each oLenErr) SHALL exist, reset to 0, saturate at 0xFFFF.
REQ-027 Without CRC_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Shared package SHALL hold the CRC-32 polynomial, init and XOR constants, the ctrl-field offsets, and the FSM state encoding.
REQ-029 Sub-module crc32_step SHALL be purely combinational: CRC-in, DATA_W data and byte count in; CRC-out.

Verification
REQ-030 DATA_W=32, len=9, words 0x31323334, 0x35363738, 0x00000039 -> CRC word 0xCBF43926, then oWrEop, oLenErr=0.
REQ-031 DATA_W=64, same "123456789" (0x3132333435363738, 0x39) -> CRC word 0x00000000CBF43926.
REQ-032 64-byte packet, then 128-byte packet with 1-cycle gaps between words -> all words forwarded at 1-cycle latency, CRC matches the bench model, two oWrEop pulses.
REQ-033 len=16 with 5 payload words -> fifth word forwarded, CRC over the first 16 bytes only, oLenErr=1.
REQ-034 iWrSop one cycle after iWrEop -> no oWrSop; iRst pulse mid-DATA -> outputs 0, no oWrEop.
REQ-035 CRC_STATS_EN defined, 3 good packets and 1 short packet -> oPktCnt=4, oErrCnt=1.
